// File: rtl/div_seq_unit_pkg.sv
// div_seq_unit_pkg: FSM state encoding and request polarity shared by the divider files
package div_seq_unit_pkg;
   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_ZERO = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;
   localparam logic DIV_START = 1'b1;
endpackage

// File: rtl/div_seq_unit_step.sv
// div_step: one combinational radix-2 restoring iteration (shift in next dividend bit, trial subtract)
module div_step
   import div_seq_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem_i,
   input  logic              dvd_bit_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic [DATA_W-1:0] rem_o,
   output logic              q_bit_o
);
   logic [DATA_W:0] diff;
   // The partial remainder stays below the divisor, so the shifted value fits DATA_W+1 bits
   // and the top bit of the difference is the borrow.
   assign diff    = {rem_i, dvd_bit_i} - {1'b0, divisor_i};
   assign q_bit_o = ~diff[DATA_W];
   assign rem_o   = q_bit_o ? diff[DATA_W-1:0] : {rem_i[DATA_W-2:0], dvd_bit_i};
endmodule

// File: rtl/div_seq_unit.sv
// div_seq_unit: multi-cycle restoring divider for DIV.W/DIVU.W/MOD.W/MODU.W; DIV_EARLY_OUT_EN skips iteration when |dividend| < |divisor|
module div_seq_unit
   import div_seq_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              signed_i,
   input  logic              cancel_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic [DATA_W-1:0] quotient_o,
   output logic [DATA_W-1:0] remainder_o,
   output logic              done_o,
   output logic              stall_o,
   output logic              busy_o
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   div_state_e        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] dvd_q, dvs_q, rem_q, quo_q, remo_q;
   logic              q_neg_q, r_neg_q;
   logic              accept, zero_div, early_out, q_bit;
   logic [DATA_W-1:0] dvd_abs, dvs_abs, step_rem, q_next;

   assign accept   = state_q == DIV_IDLE && start_i == DIV_START && !cancel_i;
   assign zero_div = divisor_i == '0;
   assign dvd_abs  = (signed_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
   assign dvs_abs  = (signed_i && divisor_i[DATA_W-1]) ? -divisor_i : divisor_i;
`ifdef DIV_EARLY_OUT_EN
   assign early_out = !zero_div && dvd_abs < dvs_abs;
`else
   assign early_out = 1'b0;
`endif

   div_step #(.DATA_W(DATA_W)) u_step (
      .rem_i     (rem_q),
      .dvd_bit_i (dvd_q[DATA_W-1]),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .q_bit_o   (q_bit)
   );

   // The dividend register shifts out its MSB each step and collects quotient bits at the LSB.
   assign q_next = {dvd_q[DATA_W-2:0], q_bit};

   // Sequencing FSM; results are sign-corrected as they are registered on entry to DONE.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         quo_q   <= '0;
         remo_q  <= '0;
      end else if (cancel_i) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
      end else
         case (state_q)
            DIV_IDLE:
               if (start_i == DIV_START) begin
                  dvd_q   <= zero_div ? dividend_i : dvd_abs;
                  dvs_q   <= dvs_abs;
                  rem_q   <= '0;
                  cnt_q   <= '0;
                  q_neg_q <= signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
                  r_neg_q <= signed_i & dividend_i[DATA_W-1];
                  state_q <= zero_div ? DIV_ZERO : early_out ? DIV_DONE : DIV_BUSY;
                  if (early_out) begin
                     quo_q  <= '0;
                     remo_q <= dividend_i;
                  end
               end
            DIV_BUSY: begin
               dvd_q <= q_next;
               rem_q <= step_rem;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_q <= DIV_DONE;
                  quo_q   <= q_neg_q ? -q_next : q_next;
                  remo_q  <= r_neg_q ? -step_rem : step_rem;
               end
            end
            DIV_ZERO: begin
               state_q <= DIV_DONE;
               quo_q   <= '1;
               remo_q  <= dvd_q;
            end
            default: begin
               state_q <= DIV_IDLE;
               cnt_q   <= '0;
            end
         endcase

   assign quotient_o  = quo_q;
   assign remainder_o = remo_q;
   assign done_o      = state_q == DIV_DONE;
   assign busy_o      = state_q != DIV_IDLE;
   assign stall_o     = !rst && (accept || state_q == DIV_BUSY || state_q == DIV_ZERO);
endmodule
